// File: rtl/adder_pkg.sv
// Shared configuration for pipelined_adder: default geometry, slice width, config check.
// No logic; constants and elaboration helpers only.
// Optional signed-overflow output is enabled by defining ADDER_OVF_EN.
package adder_pkg;

  localparam int ADDER_WIDTH  = 32;
  localparam int ADDER_STAGES = 4;

  function automatic int chunk_bits(input int width, input int stages);
    return width / stages;
  endfunction

  // Geometry is legal when every stage gets an equal, non-empty slice.
  function automatic bit cfg_ok(input int width, input int stages);
    return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/adder_pipe_stage.sv
// One slice of the pipelined adder: CHUNK-bit add plus valid/data/carry registers.
// Latency 1 cycle; holds everything while en is low (global stall).
// Final stage also registers the signed-overflow flag when ADDER_OVF_EN is defined.
module adder_pipe_stage
  import adder_pkg::*;
#(
  parameter int WIDTH = ADDER_WIDTH,
  parameter int CHUNK = 8,
  parameter int IDX   = 0,
  localparam int BIN  = WIDTH - IDX * CHUNK,
  localparam int BOUT = BIN - CHUNK,
`ifdef ADDER_OVF_EN
  localparam int XTRA = (BOUT == 0) ? 1 : 0,
`else
  localparam int XTRA = 0,
`endif
  localparam int DIN  = WIDTH + BIN,
  localparam int DOUT = WIDTH + BOUT + XTRA
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            in_vld,
  input  logic [DIN-1:0]  in_dat,
  input  logic            in_c,
  output logic            out_vld,
  output logic [DOUT-1:0] out_dat,
  output logic            out_c
);

  // in_dat = {b slices IDX and up, acc}; acc holds sum below slice IDX and a above it.
  logic [CHUNK:0]   slice;
  logic [WIDTH-1:0] acc_nxt;
  logic [DOUT-1:0]  dat_nxt;

  assign slice = {1'b0, in_dat[IDX*CHUNK +: CHUNK]}
               + {1'b0, in_dat[WIDTH +: CHUNK]}
               + {{CHUNK{1'b0}}, in_c};

  always_comb begin
    acc_nxt = in_dat[WIDTH-1:0];
    acc_nxt[IDX*CHUNK +: CHUNK] = slice[CHUNK-1:0];
  end

  if (BOUT > 0) begin : g_fwd
    assign dat_nxt = {in_dat[DIN-1:WIDTH+CHUNK], acc_nxt};
  end else begin : g_tail
`ifdef ADDER_OVF_EN
    logic a_msb;
    logic b_msb;
    assign a_msb   = in_dat[WIDTH-1];
    assign b_msb   = in_dat[DIN-1];
    assign dat_nxt = {(a_msb == b_msb) && (acc_nxt[WIDTH-1] != a_msb), acc_nxt};
`else
    assign dat_nxt = acc_nxt;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld <= 1'b0;
      out_dat <= '0;
      out_c   <= 1'b0;
    end else if (en) begin
      out_vld <= in_vld;
      out_dat <= dat_nxt;
      out_c   <= slice[CHUNK];
    end
  end

endmodule

// File: rtl/pipelined_adder.sv
// WIDTH-bit a+b+cin split into STAGES registered slices; carry ripples one slice per clock.
// Latency STAGES cycles, one result per cycle; single global stall, in_ready = !out_valid || out_ready.
// Defining ADDER_OVF_EN adds the registered signed-overflow output ovf.
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = ADDER_WIDTH,
  parameter int STAGES = ADDER_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CHUNK = chunk_bits(WIDTH, STAGES);
`ifdef ADDER_OVF_EN
  localparam int OVF_BITS = 1;
`else
  localparam int OVF_BITS = 0;
`endif

  if (!cfg_ok(WIDTH, STAGES)) begin : g_bad_cfg
    $error("pipelined_adder: need 1 <= STAGES <= WIDTH and WIDTH a multiple of STAGES");
  end

  logic advance;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int DIN  = 2 * WIDTH - k * CHUNK;
    localparam int DOUT = 2 * WIDTH - (k + 1) * CHUNK + ((k == STAGES - 1) ? OVF_BITS : 0);

    logic [DIN-1:0]  d_in;
    logic            v_in;
    logic            c_in;
    logic [DOUT-1:0] dat_q;
    logic            vld_q;
    logic            c_q;

    if (k == 0) begin : g_head
      assign d_in = {b, a};
      assign v_in = in_valid;
      assign c_in = cin;
    end else begin : g_body
      assign d_in = g_stage[k-1].dat_q;
      assign v_in = g_stage[k-1].vld_q;
      assign c_in = g_stage[k-1].c_q;
    end

    adder_pipe_stage #(
      .WIDTH (WIDTH),
      .CHUNK (CHUNK),
      .IDX   (k)
    ) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (advance),
      .in_vld  (v_in),
      .in_dat  (d_in),
      .in_c    (c_in),
      .out_vld (vld_q),
      .out_dat (dat_q),
      .out_c   (c_q)
    );
  end

  assign out_valid = g_stage[STAGES-1].vld_q;
  assign sum       = g_stage[STAGES-1].dat_q[WIDTH-1:0];
  assign cout      = g_stage[STAGES-1].c_q;
`ifdef ADDER_OVF_EN
  assign ovf       = g_stage[STAGES-1].dat_q[WIDTH];
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// Randomized and directed bench for pipelined_adder against a queue-based arithmetic model.
// Build with ADDER_OVF_EN defined to also cover the overflow output.
module tb_pipelined_adder;

  localparam int W = 32;
  localparam int S = 4;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -SMAX - 1;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
`ifdef ADDER_OVF_EN
  logic         ovf;
`endif

  pipelined_adder #(.WIDTH(W), .STAGES(S)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
`ifdef ADDER_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] s;
    logic         co;
    logic         ov;
    int           t;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;
  int   n_pop = 0;
  bit   chk_lat = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  // Reference: plain wide arithmetic, signed range test for overflow.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic c, input int t);
    exp_t        e;
    logic [W:0]  full;
    longint      r;
    full = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    r    = longint'($signed(x)) + longint'($signed(y)) + (c ? 64'sd1 : 64'sd0);
    e.s  = full[W-1:0];
    e.co = full[W];
    e.ov = (r > SMAX) || (r < SMIN);
    e.t  = t;
    return e;
  endfunction

  // Called at a negedge: drive, sample at +1, account handshakes, advance to next negedge.
  task automatic cycle(input logic iv, input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input logic ic, input logic ordy, input int want_rdy);
    exp_t e;
    in_valid  = iv;
    a         = ia;
    b         = ib;
    cin       = ic;
    out_ready = ordy;
    #1;
    if (want_rdy >= 0) chk("in_ready", {63'd0, in_ready}, want_rdy[63:0]);
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        chk("spurious_out_valid", {63'd0, out_valid}, 64'd0);
      end else begin
        e = exp_q[0];
        if (out_ready) begin
          void'(exp_q.pop_front());
          n_pop++;
          chk("sum", {32'd0, sum}, {32'd0, e.s});
          chk("cout", {63'd0, cout}, {63'd0, e.co});
`ifdef ADDER_OVF_EN
          chk("ovf", {63'd0, ovf}, {63'd0, e.ov});
`endif
          if (chk_lat) chk("latency", 64'(cyc - e.t), 64'(S));
        end else begin
          chk("stall_sum_hold", {32'd0, sum}, {32'd0, e.s});
        end
      end
    end
    if (iv && in_ready) exp_q.push_back(model(ia, ib, ic, cyc));
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle(input int n, input logic ordy);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, 1'b0, ordy, -1);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'hFFFF_FFFF;
      1: return 32'h7FFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h0000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_sum", {32'd0, sum}, 64'd0);
    chk("rst_cout", {63'd0, cout}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    @(negedge clk);

    // Full-width carry ripple and carry-in propagation, unstalled latency checked.
    chk_lat = 1'b1;
    cycle(1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 1);
    idle(S + 2, 1'b1);
    cycle(1'b1, 32'h0000_FFFF, 32'h0000_0000, 1'b1, 1'b1, 1);
    idle(S + 2, 1'b1);
    chk("directed_pops", 64'(n_pop), 64'd2);

    // Back-to-back stream, in_ready must stay high.
    n_pop = 0;
    for (int i = 0; i < 8; i++)
      cycle(1'b1, W'(i), W'(2 * i), i[0], 1'b1, 1);
    idle(S + 2, 1'b1);
    chk("stream_pops", 64'(n_pop), 64'd8);
    chk("stream_drain", 64'(exp_q.size()), 64'd0);

    // Backpressure: fill, stall 5 cycles, release.
    chk_lat = 1'b0;
    n_pop = 0;
    for (int i = 0; i < S; i++) cycle(1'b1, pick(), pick(), 1'($urandom), 1'b1, 1);
    for (int i = 0; i < 5; i++) cycle(1'b1, pick(), pick(), 1'($urandom), 1'b0, 0);
    idle(S + 4, 1'b1);
    chk("bp_pops", 64'(n_pop), 64'(S));
    chk("bp_drain", 64'(exp_q.size()), 64'd0);

    // Random traffic with random backpressure.
    for (int i = 0; i < 300; i++)
      cycle(1'($urandom_range(0, 3) != 0), pick(), pick(), 1'($urandom),
            1'($urandom_range(0, 2) != 0), -1);
    idle(S + 4, 1'b1);
    chk("rand_drain", 64'(exp_q.size()), 64'd0);

    // Asynchronous reset with three operations in flight.
    for (int i = 0; i < 3; i++) cycle(1'b1, 32'h100 + W'(i), 32'h11, 1'b0, 1'b0, -1);
    idle(1, 1'b0);
    #1 chk("pre_rst_out_valid", {63'd0, out_valid}, 64'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("midrst_sum", {32'd0, sum}, 64'd0);
    chk("midrst_cout", {63'd0, cout}, 64'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(S + 4, 1'b1);
    chk("post_rst_empty", 64'(exp_q.size()), 64'd0);

    // Signed overflow corner cases (sum/cout checked in every build).
    chk_lat = 1'b1;
    cycle(1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 1);
    cycle(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, 1);
    cycle(1'b1, 32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 1'b1, 1);
    idle(S + 2, 1'b1);
    chk("final_drain", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
